// File: rtl/adc_pkg.sv
// Shared types for the ADC window decimator: result-mode encoding and output register states.
package adc_pkg;

  typedef enum logic [1:0] {
    MODE_MEAN = 2'b00,
    MODE_MAX  = 2'b01,
    MODE_MIN  = 2'b10,
    MODE_LAST = 2'b11
  } mode_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/sample_window_acc.sv
// Accumulates one window of 2**LOG2_N accepted samples and presents the reduced result
// combinationally in the same cycle as the completing sample, flagged by a one-cycle done.
module sample_window_acc
  import adc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LOG2_N = 7,
  parameter int ROUND  = 0
) (
  input  logic              clk20,
  input  logic              rst,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              sample_en,
  input  logic              clear,
  input  mode_t             mode,
  output logic [DATA_W-1:0] result,
  output logic              done
);

  localparam int ACC_W = DATA_W + LOG2_N;
  localparam logic [LOG2_N-1:0] CNT_LAST = '1;
  localparam logic [ACC_W-1:0]  RND = (ROUND != 0) ? (ACC_W'(1) << (LOG2_N - 1)) : '0;

  logic [ACC_W-1:0]  acc;
  logic [LOG2_N-1:0] cnt;
  logic [DATA_W-1:0] max_q;
  logic [DATA_W-1:0] min_q;
  mode_t             mode_q;

  logic              accept;
  logic              first;
  logic [ACC_W-1:0]  sum_next;
  logic [ACC_W-1:0]  rounded;
  logic [DATA_W-1:0] max_next;
  logic [DATA_W-1:0] min_next;

  // The first sample of a window seeds max/min so stale extremes never leak across windows.
  always_comb begin
    accept   = sample_en && !clear;
    first    = (cnt == '0);
    sum_next = acc + ACC_W'(adc_data);
    rounded  = sum_next + RND;
    max_next = (first || (adc_data > max_q)) ? adc_data : max_q;
    min_next = (first || (adc_data < min_q)) ? adc_data : min_q;
    done     = accept && (cnt == CNT_LAST);
    result   = '0;
    case (mode_q)
      MODE_MEAN: result = rounded[ACC_W-1:LOG2_N];
      MODE_MAX:  result = max_next;
      MODE_MIN:  result = min_next;
      MODE_LAST: result = adc_data;
      default:   result = rounded[ACC_W-1:LOG2_N];
    endcase
  end

  always_ff @(posedge clk20 or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      cnt    <= '0;
      max_q  <= '0;
      min_q  <= '1;
      mode_q <= MODE_MEAN;
    end else if (clear) begin
      acc   <= '0;
      cnt   <= '0;
      max_q <= '0;
      min_q <= '1;
    end else if (accept) begin
      if (first) begin
        mode_q <= mode;
      end
      if (cnt == CNT_LAST) begin
        acc   <= '0;
        cnt   <= '0;
        max_q <= '0;
        min_q <= '1;
      end else begin
        acc   <= sum_next;
        cnt   <= cnt + LOG2_N'(1);
        max_q <= max_next;
        min_q <= min_next;
      end
    end
  end

endmodule

// File: rtl/adc_window_decimator.sv
// ADC front end: drives the parallel ADC pins, decimates windows of samples and hands results
// to the frame builder through a one-deep valid/ready output register with drop accounting.
module adc_window_decimator
  import adc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LOG2_N = 7,
  parameter int ROUND  = 0
) (
  input  logic              clk20,
  input  logic              rst,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              sample_en,
  input  logic              clear,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic [15:0]       drop_count,
  output logic              adc_clkout,
  output logic              adc_tc,
  output logic              adc_ce
);

  out_state_t        state;
  out_state_t        next_state;
  logic              load;
  logic              drop;
  logic [DATA_W-1:0] acc_result;
  logic              acc_done;

  sample_window_acc #(
    .DATA_W(DATA_W),
    .LOG2_N(LOG2_N),
    .ROUND (ROUND)
  ) u_acc (
    .clk20    (clk20),
    .rst      (rst),
    .adc_data (adc_data),
    .sample_en(sample_en),
    .clear    (clear),
    .mode     (mode_t'(mode)),
    .result   (acc_result),
    .done     (acc_done)
  );

  // A completion while full only lands if the consumer takes the held result in the same cycle.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    drop       = 1'b0;
    case (state)
      OUT_EMPTY: begin
        if (acc_done) begin
          load       = 1'b1;
          next_state = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (acc_done) begin
          if (out_ready) load = 1'b1;
          else           drop = 1'b1;
        end else if (out_ready) begin
          next_state = OUT_EMPTY;
        end
      end
      default: next_state = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk20 or posedge rst) begin
    if (rst) begin
      state      <= OUT_EMPTY;
      out_data   <= '0;
      overrun    <= 1'b0;
      drop_count <= '0;
    end else begin
      state   <= next_state;
      overrun <= drop;
      if (load) begin
        out_data <= acc_result;
      end
      if (drop && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

  assign out_valid  = (state == OUT_FULL);
  assign adc_clkout = clk20;
  assign adc_tc     = 1'b1;
  assign adc_ce     = 1'b0;

endmodule
